// File: rtl/ebr_fifo_ctrl.sv
// ebr_fifo_ctrl: first-word-fall-through FIFO controller around one
// simple-dual-port EBR (single clock, 1-cycle registered read).
// A 2-entry output stage (out reg + skid) absorbs the read latency so the
// queue sustains one word per cycle in and out.
module ebr_fifo_ctrl #(
    parameter int AW = 9,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW+1:0] level,
    output logic [AW-1:0] ram_wr_addr,
    output logic [DW-1:0] ram_wr_data,
    output logic          ram_wr_ena,
    output logic [AW-1:0] ram_rd_addr,
    output logic          ram_rd_ena,
    input  logic [DW-1:0] ram_rd_data
);

    localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   ram_cnt;
    logic          pend;
    logic [DW-1:0] out_q;
    logic          out_v;
    logic [DW-1:0] skid_q;
    logic          skid_v;

    logic          push;
    logic          pop;
    logic          rd_issue;
    logic [1:0]    occ;
    logic [1:0]    occ_limit;

    // Handshakes and read-issue decision; in_ready depends on registered state only
    always_comb begin
        in_ready  = rst_n & ~flush & (ram_cnt != FULL_CNT);
        push      = in_valid & in_ready;
        pop       = out_v & out_ready & ~flush;
        // words already committed to the output stage: out reg, skid, landing read
        occ       = {1'b0, out_v} + {1'b0, skid_v} + {1'b0, pend};
        occ_limit = pop ? 2'd3 : 2'd2;
        rd_issue  = (ram_cnt != '0) & ~flush & (occ < occ_limit);
    end

    // EBR port drive and occupancy reporting
    always_comb begin
        ram_wr_ena  = push;
        ram_wr_addr = wptr;
        ram_wr_data = in_data;
        ram_rd_ena  = rd_issue;
        ram_rd_addr = rptr;
        out_data    = out_q;
        out_valid   = out_v;
        level       = {1'b0, ram_cnt} + (AW+2)'(pend) + (AW+2)'(out_v) + (AW+2)'(skid_v);
    end

    // RAM-side bookkeeping: pointers, unread word count, read-in-flight flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            ram_cnt <= '0;
            pend    <= 1'b0;
        end else if (flush) begin
            wptr    <= '0;
            rptr    <= '0;
            ram_cnt <= '0;
            pend    <= 1'b0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (rd_issue)
                rptr <= rptr + 1'b1;
            if (push && !rd_issue)
                ram_cnt <= ram_cnt + 1'b1;
            else if (!push && rd_issue)
                ram_cnt <= ram_cnt - 1'b1;
            pend <= rd_issue;
        end
    end

    // Output stage: skid is always older than landing data, so it refills out first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= '0;
            out_v  <= 1'b0;
            skid_q <= '0;
            skid_v <= 1'b0;
        end else if (flush) begin
            out_v  <= 1'b0;
            skid_v <= 1'b0;
        end else if (pop && skid_v) begin
            out_q  <= skid_q;
            out_v  <= 1'b1;
            skid_v <= pend;
            if (pend)
                skid_q <= ram_rd_data;
        end else if (!out_v || pop) begin
            // skid is empty here: it only fills while out reg is held
            out_v <= pend;
            if (pend)
                out_q <= ram_rd_data;
        end else if (pend) begin
            skid_q <= ram_rd_data;
            skid_v <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ebr_fifo_ctrl.sv
// Testbench for ebr_fifo_ctrl: behavioural EBR model, directed vector table,
// then fill/stream/random/flush/reset sequences against a queue scoreboard.
module tb_ebr_fifo_ctrl;

    localparam int AW = 9;
    localparam int DW = 8;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [AW+1:0] level;
    logic [AW-1:0] ram_wr_addr;
    logic [DW-1:0] ram_wr_data;
    logic          ram_wr_ena;
    logic [AW-1:0] ram_rd_addr;
    logic          ram_rd_ena;
    logic [DW-1:0] ram_rd_data;

    ebr_fifo_ctrl #(.AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .level       (level),
        .ram_wr_addr (ram_wr_addr),
        .ram_wr_data (ram_wr_data),
        .ram_wr_ena  (ram_wr_ena),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_ena  (ram_rd_ena),
        .ram_rd_data (ram_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural ice40 EBR: write and registered read on the shared clock
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ram_wr_ena)
            mem[ram_wr_addr] <= ram_wr_data;
        if (ram_rd_ena)
            ram_rd_data <= mem[ram_rd_addr];
    end

    // The controller must never read and write the same address in one cycle
    always @(posedge clk) begin
        if (rst_n && ram_wr_ena && ram_rd_ena) begin
            checks++;
            if (ram_wr_addr == ram_rd_addr) begin
                errors++;
                $display("FAIL same_addr_rw: addr %0h read and written at %0t", ram_wr_addr, $time);
            end
        end
    end

    // Scoreboard state
    logic [DW-1:0] q[$];
    logic [DW-1:0] wdata;
    logic          hold_prev;
    logic [DW-1:0] hold_data;
    int            pushed;
    int            pops;
    int            rd_issued;

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        hold_prev = 1'b0;
    endtask

    // One clock of stimulus with scoreboard bookkeeping and per-cycle checks
    task automatic cycle(input logic iv, input logic ordy, input logic fl);
        @(negedge clk);
        in_valid = iv; in_data = wdata; out_ready = ordy; flush = fl;
        #1;
        chk("level_vs_sb", level, q.size());
        if (hold_prev) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, hold_data);
        end
        if (ram_rd_ena) rd_issued++;
        if (fl) begin
            chk("flush_in_ready", in_ready, 0);
            chk("flush_rd_ena", ram_rd_ena, 0);
            hold_prev = 1'b0;
        end else begin
            if (out_valid && ordy) begin
                chk("pop_sb_nonempty", q.size() > 0, 1);
                if (q.size() > 0) chk("pop_data", out_data, q.pop_front());
                pops++;
            end
            if (iv && in_ready) begin
                q.push_back(wdata);
                wdata++;
                pushed++;
            end
            hold_prev = out_valid && !ordy;
            hold_data = out_data;
        end
    endtask

    typedef struct {
        logic          iv;
        logic [DW-1:0] d;
        logic          ordy;
        logic          fl;
        logic          e_ir;
        logic          e_ov;
        logic [DW-1:0] e_od;
        int unsigned   e_lvl;
        logic          e_rde;
        logic          e_wre;
    } vec_t;

    vec_t vecs [14];

    initial begin
        //          iv  d      ordy fl   ir  ov  od     lvl rde wre
        vecs[0]  = '{1, 8'hA5, 0,   0,   1,  0,  8'h00, 0,  0,  1};
        vecs[1]  = '{0, 8'h00, 0,   0,   1,  0,  8'h00, 1,  1,  0};
        vecs[2]  = '{0, 8'h00, 0,   0,   1,  0,  8'h00, 1,  0,  0};
        vecs[3]  = '{0, 8'h00, 0,   0,   1,  1,  8'hA5, 1,  0,  0};
        vecs[4]  = '{0, 8'h00, 0,   0,   1,  1,  8'hA5, 1,  0,  0};
        vecs[5]  = '{1, 8'h11, 0,   0,   1,  1,  8'hA5, 1,  0,  1};
        vecs[6]  = '{1, 8'h22, 0,   0,   1,  1,  8'hA5, 2,  1,  1};
        vecs[7]  = '{1, 8'h33, 0,   0,   1,  1,  8'hA5, 3,  0,  1};
        vecs[8]  = '{0, 8'h00, 1,   0,   1,  1,  8'hA5, 4,  1,  0};
        vecs[9]  = '{0, 8'h00, 1,   0,   1,  1,  8'h11, 3,  1,  0};
        vecs[10] = '{0, 8'h00, 1,   0,   1,  1,  8'h22, 2,  0,  0};
        vecs[11] = '{0, 8'h00, 1,   0,   1,  1,  8'h33, 1,  0,  0};
        vecs[12] = '{1, 8'h77, 0,   1,   0,  0,  8'h00, 0,  0,  0};
        vecs[13] = '{0, 8'h00, 0,   0,   1,  0,  8'h00, 0,  0,  0};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        wdata = '0; hold_prev = 1'b0; hold_data = '0;
        pushed = 0; pops = 0; rd_issued = 0;
        #2;
        chk("reset_in_ready", in_ready, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_level", level, 0);
        chk("reset_wr_ena", ram_wr_ena, 0);
        chk("reset_rd_ena", ram_rd_ena, 0);
        do_reset();

        // Directed vector table: latency, hold, skid fill/drain order, flush
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            in_valid = vecs[i].iv; in_data = vecs[i].d; out_ready = vecs[i].ordy; flush = vecs[i].fl;
            #1;
            chk($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].e_ir);
            chk($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].e_ov);
            if (vecs[i].e_ov) chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].e_od);
            chk($sformatf("vec%0d_level", i), level, vecs[i].e_lvl);
            chk($sformatf("vec%0d_rd_ena", i), ram_rd_ena, vecs[i].e_rde);
            chk($sformatf("vec%0d_wr_ena", i), ram_wr_ena, vecs[i].e_wre);
        end

        // Fill to full with nothing popped: 512 in RAM + out reg + skid
        do_reset();
        wdata = '0; pushed = 0; rd_issued = 0;
        for (int i = 0; i < 530; i++) cycle(1'b1, 1'b0, 1'b0);
        chk("full_pushes", pushed, 514);
        chk("full_level", level, 514);
        chk("full_in_ready", in_ready, 0);
        chk("full_reads_issued", rd_issued, 2);

        // From full: continuous push and pop, one word each per cycle, across wrap
        pops = 0;
        for (int i = 0; i < 1100; i++) cycle(1'b1, 1'b1, 1'b0);
        chk("stream_pops", pops, 1100);
        chk("stream_out_valid", out_valid, 1);

        // Random push/pop traffic with the scoreboard, then drain
        do_reset();
        pushed = 0;
        for (int i = 0; i < 20000 && pushed < 4000; i++)
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        chk("rand_pushed_all", pushed >= 4000, 1);
        for (int i = 0; i < 2000 && (q.size() != 0 || out_valid); i++)
            cycle(1'b0, 1'b1, 1'b0);
        chk("rand_drained_sb", q.size(), 0);
        chk("rand_drained_level", level, 0);

        // Flush while a read is in flight
        do_reset();
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b1);
        q.delete();
        cycle(1'b0, 1'b0, 1'b0);
        chk("flush_level", level, 0);
        chk("flush_out_valid", out_valid, 0);
        wdata = 8'h3C;
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        chk("post_flush_valid", out_valid, 1);
        chk("post_flush_data", out_data, 8'h3C);

        // Asynchronous reset in the middle of a burst
        wdata = 8'h80;
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("areset_out_valid", out_valid, 0);
        chk("areset_out_data", out_data, 0);
        chk("areset_level", level, 0);
        chk("areset_in_ready", in_ready, 0);
        chk("areset_wr_ena", ram_wr_ena, 0);
        chk("areset_rd_ena", ram_rd_ena, 0);
        in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        hold_prev = 1'b0;
        wdata = 8'h5A;
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        chk("post_reset_valid", out_valid, 1);
        chk("post_reset_data", out_data, 8'h5A);
        cycle(1'b0, 1'b0, 1'b0);
        chk("post_reset_empty", level, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
